// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: DEPTH-entry elastic FIFO between pipeline stages with flush, halt and almost-full; define PIPE_BUF_BYPASS_EN for zero-latency pass-through when empty
module pipe_stage_buffer #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 2,
    parameter int AFULL_TH = 1
) (
    input  logic                         clk,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         halt_i,
    input  logic                         valid_i,
    output logic                         ack_o,
    input  logic [DATA_W-1:0]            data_i,
    output logic                         valid_o,
    input  logic                         ack_i,
    output logic [DATA_W-1:0]            data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         almost_full_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic              full, empty, open, push, pop, store, drain;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return p == LAST_C ? '0 : p + PW'(1);
    endfunction

    assign full          = count == FULL_C;
    assign empty         = count == '0;
    assign open          = !flush_i && !halt_i;
    assign ack_o         = !full && open;
    assign push          = valid_i && ack_o;
    assign pop           = valid_o && ack_i;
    assign count_o       = count;
    assign almost_full_o = count >= AFULL_C;

`ifdef PIPE_BUF_BYPASS_EN
    // empty buffer forwards upstream directly; a payload consumed in the same cycle is never stored
    assign valid_o = (!empty || valid_i) && open;
    assign data_o  = empty ? data_i : mem[rd_ptr];
    assign store   = push && !(empty && ack_i);
    assign drain   = pop && !empty;
`else
    assign valid_o = !empty && open;
    assign data_o  = mem[rd_ptr];
    assign store   = push;
    assign drain   = pop;
`endif

    // pointer and occupancy update; reset and flush both empty the buffer
    always_ff @(posedge clk) begin
        if (rst_i || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) wr_ptr <= bump(wr_ptr);
            if (drain) rd_ptr <= bump(rd_ptr);
            count <= count + CW'(store) - CW'(drain);
        end
    end

    // payload storage, written only on an accepted push that is kept
    always_ff @(posedge clk) begin
        if (store && !rst_i) mem[wr_ptr] <= data_i;
    end

    // occupancy must stay within 0..DEPTH
    always_ff @(posedge clk) begin
        if (!rst_i) assert (count <= FULL_C);
    end
endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb_pipe_stage_buffer: scoreboard bench for a DEPTH=2 and a DEPTH=3 buffer instance
module tb_pipe_stage_buffer;
    logic       clk = 0;
    logic       rst_i = 1, flush_i = 0, halt_i = 0;
    logic [1:0] vin = '0, ain = '0, aout, vout, afull;
    logic [7:0] din [2];
    logic [7:0] dout [2];
    logic [1:0] cnt [2];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int checks = 0, failures = 0, pops = 0;
    logic acc;

    always #5 clk = ~clk;

    pipe_stage_buffer #(.DATA_W(8), .DEPTH(2), .AFULL_TH(2)) u2 (
        .clk(clk), .rst_i(rst_i), .flush_i(flush_i), .halt_i(halt_i),
        .valid_i(vin[0]), .ack_o(aout[0]), .data_i(din[0]),
        .valid_o(vout[0]), .ack_i(ain[0]), .data_o(dout[0]),
        .count_o(cnt[0]), .almost_full_o(afull[0]));

    pipe_stage_buffer #(.DATA_W(8), .DEPTH(3), .AFULL_TH(3)) u3 (
        .clk(clk), .rst_i(rst_i), .flush_i(flush_i), .halt_i(halt_i),
        .valid_i(vin[1]), .ack_o(aout[1]), .data_i(din[1]),
        .valid_o(vout[1]), .ack_i(ain[1]), .data_o(dout[1]),
        .count_o(cnt[1]), .almost_full_o(afull[1]));

    task automatic step(input int k, input logic v, input logic [7:0] d, input logic a,
                        input string tag, output logic accepted);
        logic ea, ev, byp;
        logic [7:0] ed;
        int n, dep;
        vin[k] = v; din[k] = d; ain[k] = a;
        #1;
        dep = k ? 3 : 2;
        n = k ? q1.size() : q0.size();
        ea = n < dep && !flush_i && !halt_i;
        byp = 0;
`ifdef PIPE_BUF_BYPASS_EN
        byp = n == 0 && v && !flush_i && !halt_i;
`endif
        ev = (n > 0 || byp) && !flush_i && !halt_i;
        checks++;
        if (aout[k] !== ea) begin
            failures++;
            $display("FAIL %s ack_o got=%b exp=%b", tag, aout[k], ea);
        end
        checks++;
        if (vout[k] !== ev) begin
            failures++;
            $display("FAIL %s valid_o got=%b exp=%b", tag, vout[k], ev);
        end
        if (ev && a) begin
            if (byp) ed = d;
            else if (k != 0) ed = q1.pop_front();
            else ed = q0.pop_front();
            pops++;
            checks++;
            if (dout[k] !== ed) begin
                failures++;
                $display("FAIL %s data_o got=%h exp=%h", tag, dout[k], ed);
            end
        end
        accepted = v && ea;
        if (accepted && !(byp && a)) begin
            if (k != 0) q1.push_back(d);
            else q0.push_back(d);
        end
        if (flush_i) begin
            q0.delete();
            q1.delete();
        end
        @(posedge clk);
        #1;
        n = k ? q1.size() : q0.size();
        checks++;
        if (cnt[k] !== 2'(n)) begin
            failures++;
            $display("FAIL %s count_o got=%0d exp=%0d", tag, cnt[k], n);
        end
        checks++;
        if (afull[k] !== (n >= dep)) begin
            failures++;
            $display("FAIL %s almost_full_o got=%b exp=%b", tag, afull[k], n >= dep);
        end
    endtask

    task automatic do_reset();
        rst_i = 1; vin = '0; ain = '0; flush_i = 0; halt_i = 0;
        @(posedge clk);
        #1;
        rst_i = 0;
        q0.delete();
        q1.delete();
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (vout[k] !== 1'b0) begin failures++; $display("FAIL reset valid_o[%0d] got=%b exp=0", k, vout[k]); end
            checks++;
            if (aout[k] !== 1'b1) begin failures++; $display("FAIL reset ack_o[%0d] got=%b exp=1", k, aout[k]); end
            checks++;
            if (cnt[k] !== 2'd0) begin failures++; $display("FAIL reset count_o[%0d] got=%0d exp=0", k, cnt[k]); end
            checks++;
            if (afull[k] !== 1'b0) begin failures++; $display("FAIL reset almost_full_o[%0d] got=%b exp=0", k, afull[k]); end
        end
    endtask

    task automatic test_fill_drain();
        step(0, 1, 8'hA1, 0, "fill1", acc);
        step(0, 1, 8'hA2, 0, "fill2", acc);
        step(0, 1, 8'hA3, 0, "full_hold", acc);
        step(0, 0, 8'h00, 1, "drain1", acc);
        step(0, 0, 8'h00, 1, "drain2", acc);
        step(0, 0, 8'h00, 1, "empty_ack", acc);
    endtask

    task automatic test_full_push_pop();
        step(0, 1, 8'h10, 0, "pp_fill1", acc);
        step(0, 1, 8'h11, 0, "pp_fill2", acc);
        step(0, 1, 8'h12, 1, "pp_full", acc);
        step(0, 1, 8'h12, 1, "pp_both", acc);
        step(0, 0, 8'h00, 1, "pp_drain1", acc);
        step(0, 0, 8'h00, 1, "pp_drain2", acc);
    endtask

    task automatic test_wrap();
        int j = 1, cyc = 0;
        pops = 0;
        while (j <= 7 && cyc < 100) begin
            step(1, 1, 8'(j), cyc[0], "wrap_in", acc);
            if (acc) j++;
            cyc++;
        end
        while (q1.size() > 0 && cyc < 200) begin
            step(1, 0, 8'h00, 1, "wrap_out", acc);
            cyc++;
        end
        checks++;
        if (pops !== 7 || j !== 8) begin
            failures++;
            $display("FAIL wrap_total pops got=%0d exp=7 sent=%0d", pops, j - 1);
        end
    endtask

    task automatic test_flush();
        step(0, 1, 8'h40, 0, "fl_fill1", acc);
        step(0, 1, 8'h41, 0, "fl_fill2", acc);
        step(0, 0, 8'h00, 1, "fl_pop", acc);
        step(0, 1, 8'h42, 0, "fl_fill3", acc);
        flush_i = 1;
        step(0, 1, 8'h55, 0, "flush", acc);
        flush_i = 0;
        step(0, 0, 8'h00, 1, "post_flush", acc);
        step(0, 1, 8'h56, 0, "flush_refill", acc);
        step(0, 0, 8'h00, 1, "flush_refill_pop", acc);
    endtask

    task automatic test_halt();
        step(0, 1, 8'h20, 0, "h_fill1", acc);
        step(0, 1, 8'h21, 0, "h_fill2", acc);
        halt_i = 1;
        for (int i = 0; i < 3; i++) step(0, 1, 8'h66, 1, "halt", acc);
        halt_i = 0;
        step(0, 0, 8'h00, 1, "halt_rel1", acc);
        step(0, 0, 8'h00, 1, "halt_rel2", acc);
    endtask

    task automatic test_reset_mid();
        step(0, 1, 8'h30, 0, "rm_fill", acc);
        rst_i = 1; vin[0] = 1; din[0] = 8'h77; ain[0] = 1;
        @(posedge clk);
        #1;
        rst_i = 0; vin[0] = 0; ain[0] = 0;
        q0.delete();
        checks++;
        if (cnt[0] !== 2'd0 || vout[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid count_o=%0d valid_o=%b exp 0/0", cnt[0], vout[0]);
        end
        step(0, 0, 8'h00, 1, "reset_mid_empty", acc);
    endtask

    task automatic test_bypass();
        step(0, 1, 8'h99, 1, "bypass", acc);
        step(0, 0, 8'h00, 1, "bypass_after", acc);
    endtask

    initial begin
        din[0] = '0; din[1] = '0;
        test_reset();
        test_fill_drain();
        test_full_push_pop();
        test_wrap();
        test_flush();
        test_halt();
        test_reset_mid();
        test_bypass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
